// File: rtl/tx_resp_scheduler.sv
// ---------------------------------------------------------------------------------------------
// tx_resp_scheduler
//   Arbitrates the single TX FIFO write port between two response sources:
//     - the ALU result path (RES_W-bit result, sent as two bytes, LSB first)
//     - the register-file read path (one DATA_W-bit byte)
//   Round-robin between the sources when both request in the same cycle. A frame is never
//   interleaved with another one, and pushes stall for as long as the FIFO reports full.
//
// Ports
//   clk           system clock, rising edge
//   rst           asynchronous active-high reset
//   alu_res       ALU result, stable while alu_vld is high
//   alu_vld       ALU response request, held until alu_ack
//   alu_ack       one-cycle pulse the cycle after the ALU result is captured
//   rd_data       register-file read byte, stable while rd_vld is high
//   rd_vld        read response request, held until rd_ack
//   rd_ack        one-cycle pulse the cycle after the read byte is captured
//   fifo_full     TX FIFO full; no write is issued while high
//   fifo_wr_data  byte presented to the FIFO (0 when idle)
//   fifo_wr_inc   FIFO write strobe, one byte per high cycle
//   busy          high whenever a frame is in progress
//   frame_cnt     completed-frame counter, wraps to 0
// ---------------------------------------------------------------------------------------------
module tx_resp_scheduler #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned RES_W  = 16,
    parameter int unsigned CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [RES_W-1:0]  alu_res,
    input  logic              alu_vld,
    output logic              alu_ack,
    input  logic [DATA_W-1:0] rd_data,
    input  logic              rd_vld,
    output logic              rd_ack,
    input  logic              fifo_full,
    output logic [DATA_W-1:0] fifo_wr_data,
    output logic              fifo_wr_inc,
    output logic              busy,
    output logic [CNT_W-1:0]  frame_cnt
);

    typedef enum logic [1:0] {
        StIdle,
        StSendRd,
        StSendLo,
        StSendHi
    } state_e;

    // Round-robin pointer: which source wins when both request together.
    localparam logic PrioAlu = 1'b0;
    localparam logic PrioRd  = 1'b1;

    state_e             state_q, state_d;
    logic [RES_W-1:0]   hold_q, hold_d;
    logic               prio_q, prio_d;
    logic               alu_ack_q, alu_ack_d;
    logic               rd_ack_q, rd_ack_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               grant_alu;
    logic               grant_rd;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            hold_q    <= '0;
            prio_q    <= PrioAlu;
            alu_ack_q <= 1'b0;
            rd_ack_q  <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            hold_q    <= hold_d;
            prio_q    <= prio_d;
            alu_ack_q <= alu_ack_d;
            rd_ack_q  <= rd_ack_d;
            cnt_q     <= cnt_d;
        end
    end

    // Requests only matter in IDLE; the state check is applied in the FSM below.
    assign grant_alu = alu_vld && (!rd_vld || (prio_q == PrioAlu));
    assign grant_rd  = rd_vld && !grant_alu;

    always_comb begin
        state_d      = state_q;
        hold_d       = hold_q;
        prio_d       = prio_q;
        alu_ack_d    = 1'b0;
        rd_ack_d     = 1'b0;
        cnt_d        = cnt_q;
        fifo_wr_inc  = 1'b0;
        fifo_wr_data = '0;

        case (state_q)
            StIdle: begin
                if (grant_alu) begin
                    hold_d    = alu_res;
                    alu_ack_d = 1'b1;
                    prio_d    = PrioRd;
                    state_d   = StSendLo;
                end else if (grant_rd) begin
                    hold_d[DATA_W-1:0] = rd_data;
                    rd_ack_d           = 1'b1;
                    prio_d             = PrioAlu;
                    state_d            = StSendRd;
                end
            end
            StSendRd: begin
                fifo_wr_data = hold_q[DATA_W-1:0];
                if (!fifo_full) begin
                    fifo_wr_inc = 1'b1;
                    cnt_d       = cnt_q + CNT_W'(1);
                    state_d     = StIdle;
                end
            end
            StSendLo: begin
                fifo_wr_data = hold_q[DATA_W-1:0];
                if (!fifo_full) begin
                    fifo_wr_inc = 1'b1;
                    state_d     = StSendHi;
                end
            end
            StSendHi: begin
                fifo_wr_data = hold_q[RES_W-1:DATA_W];
                if (!fifo_full) begin
                    fifo_wr_inc = 1'b1;
                    cnt_d       = cnt_q + CNT_W'(1);
                    state_d     = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign alu_ack   = alu_ack_q;
    assign rd_ack    = rd_ack_q;
    assign busy      = (state_q != StIdle);
    assign frame_cnt = cnt_q;

endmodule
